// File: rtl/clarvi_rf_pkg.sv
// ----------------------------------------------------------------------------
// | Module   : clarvi_rf_pkg                                                   |
// | Purpose  : Shared types and default geometry for the part-serial Clarvi    |
// |            register file.                                                  |
// | Revision : 1.0                                                             |
// ----------------------------------------------------------------------------
`default_nettype none

package clarvi_rf_pkg;

  // Default geometry: 32 x 64-bit registers held as 8-bit parts
  localparam int XLEN_DEF   = 64;
  localparam int PART_W_DEF = 8;
  localparam int NREGS_DEF  = 32;

  // Derived widths for the default geometry
  localparam int NPARTS     = XLEN_DEF / PART_W_DEF;
  localparam int REG_IDX_W  = $clog2(NREGS_DEF);
  localparam int PART_IDX_W = $clog2(NPARTS);

  // Read sequencer states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } rf_rd_state_t;

endpackage

`default_nettype wire

// File: rtl/clarvi_rf_bram.sv
// ----------------------------------------------------------------------------
// | Module   : clarvi_rf_bram                                                  |
// | Purpose  : One write port, two synchronous read ports. Each read port has  |
// |            its own copy of the array so each copy maps onto a simple       |
// |            dual-port block RAM. Read-first on address collision. No reset. |
// | Revision : 1.0                                                             |
// ----------------------------------------------------------------------------
`default_nettype none

module clarvi_rf_bram #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_1,
  input  logic [ADDR_W-1:0] raddr_2,
  output logic [WIDTH-1:0]  rdata_1,
  output logic [WIDTH-1:0]  rdata_2
);

  logic [ADDR_W-1:0] raddr [2];

  assign raddr[0] = raddr_1;
  assign raddr[1] = raddr_2;

  for (genvar i = 0; i < 2; i++) begin : g_copy
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] q;

    // Replicated write, private registered read (old data on collision)
    always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
      q <= mem[raddr[i]];
    end
  end

  assign rdata_1 = g_copy[0].q;
  assign rdata_2 = g_copy[1].q;

endmodule

`default_nettype wire

// File: rtl/clarvi_serial_regfile.sv
// ----------------------------------------------------------------------------
// | Module   : clarvi_serial_regfile                                           |
// | Purpose  : Part-serial register file. A read sequencer streams two source  |
// |            registers one part per cycle; a write sequencer assembles a     |
// |            destination register from part beats. Register 0 is zero.      |
// | Config   : CLARVI_RF_BYPASS_EN - write-first forwarding when a read and a  |
// |            write hit the same {register, part} in the same cycle.          |
// |            Undefined: read-first (old RAM contents).                       |
// | Revision : 1.0                                                             |
// ----------------------------------------------------------------------------
`default_nettype none

module clarvi_serial_regfile
  import clarvi_rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int PART_W = PART_W_DEF,
  parameter int NREGS  = NREGS_DEF
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            rd_start,
  input  logic [$clog2(NREGS)-1:0]        rd_reg_1,
  input  logic [$clog2(NREGS)-1:0]        rd_reg_2,
  output logic                            rd_ready,
  output logic                            rd_valid,
  output logic [$clog2(XLEN/PART_W)-1:0]  rd_part,
  output logic                            rd_last,
  output logic [PART_W-1:0]               rd_data_1,
  output logic [PART_W-1:0]               rd_data_2,
  input  logic                            wr_valid,
  input  logic [$clog2(NREGS)-1:0]        wr_reg,
  input  logic [PART_W-1:0]               wr_data,
  output logic                            wr_done
);

  localparam int NP    = XLEN / PART_W;
  localparam int RW    = $clog2(NREGS);
  localparam int PW    = $clog2(NP);
  localparam int DEPTH = NREGS * NP;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [PW-1:0] LAST_PART = PW'(NP - 1);

  // Flat RAM address of {register, part}
  function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] r, input logic [PW-1:0] p);
    return AW'(r) * AW'(NP) + AW'(p);
  endfunction

  // ---------------- read sequencer ----------------
  rf_rd_state_t   state;
  logic [PW-1:0]  rd_cnt;
  logic [RW-1:0]  src_1, src_2;

  logic           issue;
  logic [PW-1:0]  issue_part;
  logic [RW-1:0]  issue_reg_1, issue_reg_2;

  // Select the part to send to the RAM this cycle
  always_comb begin
    issue       = 1'b0;
    issue_part  = rd_cnt;
    issue_reg_1 = src_1;
    issue_reg_2 = src_2;
    if (state == IDLE) begin
      issue       = rd_start;
      issue_part  = '0;
      issue_reg_1 = rd_reg_1;
      issue_reg_2 = rd_reg_2;
    end else begin
      issue = 1'b1;
    end
  end

  assign rd_ready = (state == IDLE);

  // Read FSM: accept a request in IDLE, walk the remaining parts in BUSY
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      rd_cnt <= '0;
      src_1  <= '0;
      src_2  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_start) begin
            src_1  <= rd_reg_1;
            src_2  <= rd_reg_2;
            rd_cnt <= PW'(1);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (rd_cnt == LAST_PART) begin
            rd_cnt <= '0;
            state  <= IDLE;
          end else begin
            rd_cnt <= rd_cnt + PW'(1);
          end
        end
        default: begin
          rd_cnt <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

  logic zero_1, zero_2;

  // Stream qualifiers registered alongside the synchronous RAM output
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_part  <= '0;
      rd_last  <= 1'b0;
      zero_1   <= 1'b0;
      zero_2   <= 1'b0;
    end else begin
      rd_valid <= issue;
      rd_part  <= issue_part;
      rd_last  <= issue && (issue_part == LAST_PART);
      zero_1   <= (issue_reg_1 == '0);
      zero_2   <= (issue_reg_2 == '0);
    end
  end

  // ---------------- write sequencer ----------------
  logic [PW-1:0] wr_cnt;
  logic [RW-1:0] wr_reg_q;
  logic [RW-1:0] wr_target;
  logic          ram_we;

  // Beat 0 takes the live index, later beats use the latched one
  assign wr_target = (wr_cnt == '0) ? wr_reg : wr_reg_q;
  // Register 0 never touches the RAM, but its beats are still counted
  assign ram_we    = reset_n && wr_valid && (wr_target != '0);

  // Beat counter, destination latch and completion pulse
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_cnt   <= '0;
      wr_reg_q <= '0;
      wr_done  <= 1'b0;
    end else begin
      wr_done <= wr_valid && (wr_cnt == LAST_PART);
      if (wr_valid) begin
        if (wr_cnt == '0) wr_reg_q <= wr_reg;
        wr_cnt <= (wr_cnt == LAST_PART) ? '0 : wr_cnt + PW'(1);
      end
    end
  end

  // ---------------- storage ----------------
  logic [AW-1:0]     raddr_1, raddr_2, waddr;
  logic [PART_W-1:0] ram_1, ram_2;

  assign raddr_1 = addr_of(issue_reg_1, issue_part);
  assign raddr_2 = addr_of(issue_reg_2, issue_part);
  assign waddr   = addr_of(wr_target, wr_cnt);

  clarvi_rf_bram #(
    .WIDTH  (PART_W),
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) u_bram (
    .clock   (clock),
    .we      (ram_we),
    .waddr   (waddr),
    .wdata   (wr_data),
    .raddr_1 (raddr_1),
    .raddr_2 (raddr_2),
    .rdata_1 (ram_1),
    .rdata_2 (ram_2)
  );

  logic [PART_W-1:0] sel_1, sel_2;

`ifdef CLARVI_RF_BYPASS_EN
  logic              byp_1, byp_2;
  logic [PART_W-1:0] byp_data;

  // Remember a same-cycle write to the address each port is reading
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      byp_1    <= 1'b0;
      byp_2    <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_1    <= ram_we && (waddr == raddr_1);
      byp_2    <= ram_we && (waddr == raddr_2);
      byp_data <= wr_data;
    end
  end

  assign sel_1 = byp_1 ? byp_data : ram_1;
  assign sel_2 = byp_2 ? byp_data : ram_2;
`else
  assign sel_1 = ram_1;
  assign sel_2 = ram_2;
`endif

  // Zero-register masking wins over RAM and bypass; idle outputs are low
  assign rd_data_1 = (rd_valid && !zero_1) ? sel_1 : '0;
  assign rd_data_2 = (rd_valid && !zero_2) ? sel_2 : '0;

endmodule

`default_nettype wire

// File: tb/tb_clarvi_serial_regfile.sv
// ----------------------------------------------------------------------------
// | Module   : tb_clarvi_serial_regfile                                        |
// | Purpose  : Self-checking bench for clarvi_serial_regfile (default sizes).  |
// | Config   : honours CLARVI_RF_BYPASS_EN for the collision expectation.      |
// | Revision : 1.0                                                             |
// ----------------------------------------------------------------------------
`default_nettype none

module tb_clarvi_serial_regfile;

  localparam int NP = 8;

`ifdef CLARVI_RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rd_start;
  logic [4:0] rd_reg_1, rd_reg_2;
  logic       rd_ready, rd_valid, rd_last;
  logic [2:0] rd_part;
  logic [7:0] rd_data_1, rd_data_2;
  logic       wr_valid;
  logic [4:0] wr_reg;
  logic [7:0] wr_data;
  logic       wr_done;

  clarvi_serial_regfile dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rd_start  (rd_start),
    .rd_reg_1  (rd_reg_1),
    .rd_reg_2  (rd_reg_2),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_part   (rd_part),
    .rd_last   (rd_last),
    .rd_data_1 (rd_data_1),
    .rd_data_2 (rd_data_2),
    .wr_valid  (wr_valid),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .wr_done   (wr_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Register contents as an array of parts plus simple progress counters.
  logic [7:0] mem [32][NP];
  int  pend;        // parts of the current read still to be issued
  int  r1, r2;      // registers being streamed
  int  wbeat;       // next beat index of the write in progress
  int  wdest;       // destination of the write in progress
  bit  model_on = 1'b0;
  bit  exp_valid, exp_last, exp_done;
  int  exp_part;
  logic [7:0] exp_d1, exp_d2;

  function automatic logic [7:0] part_val(input int r, input int p, input bit wv,
                                          input int wt, input int wb, input logic [7:0] wd,
                                          input logic [7:0] cur);
    if (r == 0) return 8'h00;
    if (BYPASS && wv && wt == r && wb == p) return wd;
    return cur;
  endfunction

  always @(posedge clock) begin
    int p;
    int wt;
    bit iss;
    if (!reset_n) begin
      pend = 0; wbeat = 0; exp_valid = 0; exp_done = 0; model_on = 1'b1;
    end else begin
      iss = 1'b0;
      p = 0;
      if (pend == 0 && rd_start) begin
        r1 = int'(rd_reg_1); r2 = int'(rd_reg_2); p = 0; pend = NP - 1; iss = 1'b1;
      end else if (pend > 0) begin
        p = NP - pend; pend--; iss = 1'b1;
      end
      wt = (wbeat == 0) ? int'(wr_reg) : wdest;
      exp_valid = iss;
      if (iss) begin
        exp_part = p;
        exp_last = (p == NP - 1);
        exp_d1 = part_val(r1, p, wr_valid, wt, wbeat, wr_data, mem[r1][p]);
        exp_d2 = part_val(r2, p, wr_valid, wt, wbeat, wr_data, mem[r2][p]);
      end
      exp_done = wr_valid && (wbeat == NP - 1);
      if (wr_valid) begin
        if (wbeat == 0) wdest = int'(wr_reg);
        if (wt != 0) mem[wt][wbeat] = wr_data;
        wbeat = (wbeat + 1) % NP;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clock) begin
    if (model_on) begin
      check("rd_ready", rd_ready, pend == 0);
      check("rd_valid", rd_valid, exp_valid);
      if (exp_valid) begin
        check("rd_part", rd_part, exp_part);
        check("rd_last", rd_last, exp_last);
        check("rd_data_1", rd_data_1, exp_d1);
        check("rd_data_2", rd_data_2, exp_d2);
      end
      check("wr_done", wr_done, exp_done);
    end
    if (wr_done) done_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input int r, input logic [63:0] v, input bit gaps);
    done_cnt = 0;
    for (int k = 0; k < NP; k++) begin
      wr_valid = 1'b1;
      wr_reg   = (k == 0) ? 5'(r) : ~5'(r);
      wr_data  = v[8*k +: 8];
      @(negedge clock);
      wr_valid = 1'b0;
      if (gaps && k < NP - 1) idle(1 + (k % 3));
    end
    idle(2);
    check("wr_done_count", done_cnt, 1);
  endtask

  task automatic rd_lit(input int a, input int b, input logic [63:0] v1, input logic [63:0] v2);
    rd_start = 1'b1; rd_reg_1 = 5'(a); rd_reg_2 = 5'(b);
    @(negedge clock);
    rd_start = 1'b0;
    for (int i = 0; i < NP; i++) begin
      check("lit_data_1", rd_data_1, v1[8*i +: 8]);
      check("lit_data_2", rd_data_2, v2[8*i +: 8]);
      check("lit_last", rd_last, i == NP - 1);
      @(negedge clock);
    end
  endtask

  initial begin
    int nvalid;
    reset_n = 1'b0; rd_start = 1'b0; rd_reg_1 = '0; rd_reg_2 = '0;
    wr_valid = 1'b0; wr_reg = '0; wr_data = '0;
    idle(3);
    check("reset_rd_ready", rd_ready, 1);
    check("reset_rd_valid", rd_valid, 0);
    reset_n = 1'b1;
    idle(1);

    // Known contents for every register
    for (int r = 1; r < 32; r++)
      wr(r, {8{8'(r)}} ^ 64'h0F1E2D3C4B5A6978, 1'b0);

    // Basic write then read, second port on register 0
    wr(5, 64'h0123456789ABCDEF, 1'b0);
    rd_lit(5, 0, 64'h0123456789ABCDEF, 64'h0);

    // Register 0 ignores writes
    wr(0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    rd_lit(0, 0, 64'h0, 64'h0);

    // Back-to-back reads with no bubble
    nvalid = 0;
    rd_start = 1'b1; rd_reg_1 = 5'd3; rd_reg_2 = 5'd4;
    @(negedge clock);
    for (int i = 1; i <= 16; i++) begin
      if (rd_valid) nvalid++;
      if (i <= 7) check("b2b_ready_low", rd_ready, 0);
      if (i == 8) begin
        check("b2b_ready_high", rd_ready, 1);
        rd_start = 1'b1; rd_reg_1 = 5'd7; rd_reg_2 = 5'd8;
      end else begin
        rd_start = 1'b0;
      end
      @(negedge clock);
    end
    check("b2b_valid_count", nvalid, 16);
    idle(2);

    // Same-cycle read/write collision on reg 9 part 2
    wr(9, 64'h0, 1'b0);
    rd_start = 1'b1; rd_reg_1 = 5'd9; rd_reg_2 = 5'd9;
    wr_valid = 1'b1; wr_reg = 5'd9; wr_data = 8'h00;
    @(negedge clock);
    rd_start = 1'b0; wr_reg = 5'd1; wr_data = 8'h00;
    @(negedge clock);
    wr_data = 8'hAA;
    @(negedge clock);
    wr_data = 8'h00;
    check("byp_part", rd_part, 2);
    check("byp_data_1", rd_data_1, BYPASS ? 8'hAA : 8'h00);
    check("byp_data_2", rd_data_2, BYPASS ? 8'hAA : 8'h00);
    for (int k = 3; k < NP; k++) @(negedge clock);
    wr_valid = 1'b0;
    idle(4);

    // Reset in the middle of a write and a read
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1; wr_reg = 5'd10; wr_data = 8'(8'h11 * (k + 1));
      @(negedge clock);
    end
    wr_valid = 1'b0;
    rd_start = 1'b1; rd_reg_1 = 5'd6; rd_reg_2 = 5'd6;
    @(negedge clock);
    rd_start = 1'b0;
    idle(2);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_ready", rd_ready, 1);
    idle(1);
    wr(11, 64'hFEDCBA9876543210, 1'b0);
    rd_lit(11, 10, 64'hFEDCBA9876543210, 64'h0514273644332211);

    // Write beats separated by idle gaps
    wr(12, 64'h8899AABBCCDDEEFF, 1'b1);
    rd_lit(12, 12, 64'h8899AABBCCDDEEFF, 64'h8899AABBCCDDEEFF);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
